// File: rtl/vga_fb_writer_pkg.sv
// Shared constants and FSM encoding for the 64x64 framebuffer write side.
// The double-buffer option is selected with the FB_DOUBLE_BUF_EN macro.
package vga_fb_writer_pkg;

  localparam int FB_W        = 64;
  localparam int FB_H        = 64;
  localparam int FB_XY_W     = 6;
  localparam int FB_DATA_W   = 8;
  localparam int FB_ADDR_W   = 2 * FB_XY_W;
  localparam int FB_CLR_LAST = FB_W * FB_H - 1;

  typedef enum logic [1:0] {
    FB_ST_IDLE      = 2'd0,
    FB_ST_CLEAR     = 2'd1,
    FB_ST_SWAP_WAIT = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are not reset; only the read register is.
module fb_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Same-address read/write in one cycle returns the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_fb_writer.sv
// Framebuffer write side: pixel writes, clear-screen fill, bank swap on v_sync and the VGA read port.
// Define FB_DOUBLE_BUF_EN for two banks (writes go to back, reads from front).
module vga_fb_writer
  import vga_fb_writer_pkg::*;
#(
  parameter int DATA_W = FB_DATA_W,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [FB_XY_W-1:0] wr_x,
  input  logic [FB_XY_W-1:0] wr_y,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               clr_req,
  input  logic [DATA_W-1:0]  clr_val,
  input  logic               swap_req,
  output logic               swap_done,
  output logic               busy,
  input  logic               v_sync,
  input  logic [ADDR_W-1:0]  vga_addr,
  output logic [DATA_W-1:0]  vga_data,
  output logic [1:0]         dbg_state
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(FB_CLR_LAST);

  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] clr_val_q;
  logic              vsync_q;
  logic              swap_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Handshake: a write is accepted on a rising edge where wr_valid && wr_ready;
  // ready drops only when not IDLE or when a clear/swap request is pending.
  assign wr_ready  = (state == FB_ST_IDLE) && !clr_req && !swap_req;
  assign busy      = (state != FB_ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = {wr_y, wr_x};
    mem_wdata = wr_data;
    swap_done = 1'b0;
    case (state)
      FB_ST_IDLE: begin
        if (clr_req)       state_nxt = FB_ST_CLEAR;
        else if (swap_req) state_nxt = FB_ST_SWAP_WAIT;
        else if (wr_valid) mem_we    = 1'b1;
      end
      FB_ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = clr_val_q;
        if (cnt == CNT_LAST) state_nxt = FB_ST_IDLE;
      end
      FB_ST_SWAP_WAIT: begin
        if (swap_fire) begin
          swap_done = 1'b1;
          state_nxt = FB_ST_IDLE;
        end
      end
      default: state_nxt = FB_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FB_ST_IDLE;
      cnt       <= '0;
      clr_val_q <= '0;
      vsync_q   <= 1'b1;
    end else begin
      state   <= state_nxt;
      vsync_q <= v_sync;
      if (state == FB_ST_IDLE && clr_req) begin
        cnt       <= '0;
        clr_val_q <= clr_val;
      end else if (state == FB_ST_CLEAR) begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

`ifdef FB_DOUBLE_BUF_EN
  logic              front;
  logic              rd_sel;
  logic [DATA_W-1:0] q0, q1;

  assign swap_fire = vsync_q & ~v_sync;

  // rd_sel follows front one cycle late so the mux lines up with the registered bank outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front  <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      rd_sel <= front;
      if (state == FB_ST_SWAP_WAIT && swap_fire) front <= ~front;
    end
  end

  fb_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(mem_we & front), .wr_addr(mem_addr), .wr_data(mem_wdata),
    .rd_addr(vga_addr), .rd_data(q0)
  );

  fb_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk(clk), .rst(rst), .we(mem_we & ~front), .wr_addr(mem_addr), .wr_data(mem_wdata),
    .rd_addr(vga_addr), .rd_data(q1)
  );

  assign vga_data = rd_sel ? q1 : q0;
`else
  // Single bank: the swap is a one-cycle acknowledge and v_sync is not used.
  logic unused_vsync;
  assign unused_vsync = &{1'b0, v_sync, vsync_q};
  assign swap_fire    = 1'b1;

  fb_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(mem_we), .wr_addr(mem_addr), .wr_data(mem_wdata),
    .rd_addr(vga_addr), .rd_data(vga_data)
  );
`endif

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: reset, writes/readback, clear fill, reset mid-clear, swap.
// Covers the single-bank build by default and the double-buffer build under FB_DOUBLE_BUF_EN.
module tb_vga_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_x = '0;
  logic [5:0]  wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        clr_req = 1'b0;
  logic [7:0]  clr_val = '0;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic        busy;
  logic        v_sync = 1'b1;
  logic [11:0] vga_addr = '0;
  logic [7:0]  vga_data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  vga_fb_writer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .clr_req(clr_req), .clr_val(clr_val), .swap_req(swap_req),
    .swap_done(swap_done), .busy(busy), .v_sync(v_sync), .vga_addr(vga_addr),
    .vga_data(vga_data), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic write_px(input logic [5:0] x, input logic [5:0] y, input logic [7:0] d);
    wr_x = x; wr_y = y; wr_data = d; wr_valid = 1'b1;
    #1 check_eq("wr_ready_idle", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input logic [11:0] a, output logic [7:0] d);
    vga_addr = a;
    tick();
    d = vga_data;
  endtask

  task automatic run_clear(input logic [7:0] v, input bit compete, output int busy_cycles);
    clr_req = 1'b1; clr_val = v;
    if (compete) begin
      wr_x = 6'd5; wr_y = 6'd3; wr_data = 8'hEE; wr_valid = 1'b1;
    end
    #1 check_eq("clr_wr_ready", wr_ready, 0);
    tick();
    clr_req = 1'b0; wr_valid = 1'b0; clr_val = 8'h00;
    busy_cycles = 0;
    while (busy && busy_cycles < 5000) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic sweep(input string tag, input logic [7:0] v);
    int bad = 0;
    logic [7:0] d;
    for (int a = 0; a < 4096; a++) begin
      read_px(12'(a), d);
      if (d !== v) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

`ifdef FB_DOUBLE_BUF_EN
  // Holds swap_req with v_sync high, then drops v_sync to trigger the swap.
  task automatic publish();
    v_sync = 1'b1; swap_req = 1'b1;
    #1 check_eq("swap_wr_ready", wr_ready, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("swap_no_done_before_vsync", swap_done, 0);
      check_eq("swap_wait_busy", busy, 1);
      tick();
    end
    v_sync = 1'b0;
    #1 check_eq("swap_done_on_fall", swap_done, 1);
    swap_req = 1'b0;
    tick();
    check_eq("swap_done_pulse_end", swap_done, 0);
    check_eq("swap_back_idle", busy, 0);
    v_sync = 1'b1;
    tick();
  endtask
`else
  task automatic publish();
    tick();
  endtask
`endif

  initial begin
    logic [7:0] d;
    int n;

    // 1: reset state, then release with traffic pending
    wr_valid = 1'b1; wr_x = 6'd1; wr_y = 6'd1; wr_data = 8'h12;
    repeat (2) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_swap_done", swap_done, 0);
    check_eq("rst_vga_data", vga_data, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b1;
    #1 check_eq("rst_wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;

    // 2: directed writes and readback through the expected queue
    write_px(6'd5, 6'd3, 8'hA5);   exp_q.push_back(8'hA5);
    write_px(6'd63, 6'd63, 8'h5A); exp_q.push_back(8'h5A);
    write_px(6'd0, 6'd0, 8'h77);   exp_q.push_back(8'h77);
    write_px(6'd63, 6'd0, 8'hC3);  exp_q.push_back(8'hC3);
    publish();
    read_px(12'h0C5, d); check_eq("rd_0C5", d, exp_q.pop_front());
    read_px(12'hFFF, d); check_eq("rd_FFF", d, exp_q.pop_front());
    read_px(12'h000, d); check_eq("rd_000", d, exp_q.pop_front());
    read_px(12'h03F, d); check_eq("rd_03F", d, exp_q.pop_front());

`ifndef FB_DOUBLE_BUF_EN
    // Read and write of the same address in one cycle returns the old value
    vga_addr = 12'h0C5; wr_x = 6'd5; wr_y = 6'd3; wr_data = 8'h99; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check_eq("rdw_old", vga_data, 8'hA5);
    tick();
    check_eq("rdw_new", vga_data, 8'h99);
`endif

    // 3: clear with a competing write
    run_clear(8'h3C, 1'b1, n);
    check_eq("clr_busy_cycles", n, 4096);
    check_eq("clr_idle_after", dbg_state, 0);
`ifdef FB_DOUBLE_BUF_EN
    read_px(12'h0C5, d); check_eq("clr_front_untouched", d, 8'hA5);
`endif
    publish();
    read_px(12'h0C5, d); check_eq("clr_competing_dropped", d, 8'h3C);
    sweep("clr_sweep_3c", 8'h3C);

    // 4: reset at clear cycle 100, then a full clear
    clr_req = 1'b1; clr_val = 8'h55;
    tick();
    clr_req = 1'b0;
    repeat (99) tick();
    check_eq("clr100_busy", busy, 1);
    check_eq("clr100_state", dbg_state, 1);
    rst = 1'b0;
    #1 check_eq("midclr_rst_busy", busy, 0);
    check_eq("midclr_rst_state", dbg_state, 0);
    tick();
    rst = 1'b1;
    tick();
    run_clear(8'h81, 1'b0, n);
    check_eq("clr2_busy_cycles", n, 4096);
    publish();
    sweep("clr2_sweep_81", 8'h81);

`ifdef FB_DOUBLE_BUF_EN
    // 5: write to back bank is invisible until the v_sync-timed swap
    write_px(6'd0, 6'd0, 8'h11);
    read_px(12'h000, d); check_eq("dbl_front_old", d, 8'h81);
    publish();
    read_px(12'h000, d); check_eq("dbl_after_swap", d, 8'h11);
    read_px(12'h0C5, d); check_eq("dbl_back_other", d, 8'h3C);
`else
    // 6: single-bank swap acks one cycle after acceptance and has priority over a write
    swap_req = 1'b1; wr_x = 6'd0; wr_y = 6'd0; wr_data = 8'hEE; wr_valid = 1'b1;
    #1 check_eq("sb_swap_wr_ready", wr_ready, 0);
    check_eq("sb_swap_done_pre", swap_done, 0);
    tick();
    wr_valid = 1'b0;
    check_eq("sb_swap_state", dbg_state, 2);
    check_eq("sb_swap_done", swap_done, 1);
    v_sync = 1'b0;
    swap_req = 1'b0;
    tick();
    check_eq("sb_swap_done_end", swap_done, 0);
    check_eq("sb_swap_idle", busy, 0);
    v_sync = 1'b1;
    tick();
    v_sync = 1'b0;
    tick();
    v_sync = 1'b1;
    check_eq("sb_vsync_no_swap", swap_done, 0);
    read_px(12'h000, d); check_eq("sb_addr0_kept", d, 8'h81);
    read_px(12'h0C5, d); check_eq("sb_0C5_kept", d, 8'h81);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
